// File: rtl/uart_status_irq_ctrl.sv
// Status/interrupt register bank for NUM_CH UART-style channels: live mirror, sticky events, overrun, mask, irq.
// Optional irq re-assert holdoff FSM enabled by defining UART_STATUS_IRQ_HOLDOFF_EN.
module uart_status_irq_ctrl #(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned HOLDOFF_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] active_i,
   input  logic [NUM_CH-1:0] done_i,
   input  logic              clear_flags_i,
   input  logic [1:0]        addr_i,
   input  logic              wr_en_i,
   input  logic [7:0]        wdata_i,
   input  logic              rd_en_i,
   output logic [7:0]        rdata_o,
   output logic              irq_o
);

   localparam int unsigned W = 8;
   localparam logic [1:0] ADDR_STATUS  = 2'd0;
   localparam logic [1:0] ADDR_EVENT   = 2'd1;
   localparam logic [1:0] ADDR_MASK    = 2'd2;
   localparam logic [1:0] ADDR_OVERRUN = 2'd3;

   logic [NUM_CH-1:0] live_q, live_d;
   logic [NUM_CH-1:0] event_q, event_d;
   logic [NUM_CH-1:0] overrun_q, overrun_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [W-1:0]      rdata_q, rdata_d;
   logic              irq_q, irq_d;
   logic [NUM_CH-1:0] w1c_evt, w1c_ovr, ovr_set;
   logic              pending;

   // Upper wdata bits are not stored; parameter folded in to keep it referenced in every build.
   logic unused_bits;
   assign unused_bits = ^{wdata_i, 8'(HOLDOFF_CYCLES)};

   always_comb begin
      w1c_evt = (wr_en_i && addr_i == ADDR_EVENT)   ? wdata_i[NUM_CH-1:0] : '0;
      w1c_ovr = (wr_en_i && addr_i == ADDR_OVERRUN) ? wdata_i[NUM_CH-1:0] : '0;
      ovr_set = done_i & event_q & ~w1c_evt;
      pending = |(event_q & mask_q);

      live_d    = clear_flags_i ? '0 : active_i;
      // A done pulse beats a same-cycle W1C so no event is lost.
      event_d   = clear_flags_i ? '0 : (done_i | (event_q & ~w1c_evt));
      overrun_d = clear_flags_i ? '0 : (ovr_set | (overrun_q & ~w1c_ovr));
      mask_d    = (wr_en_i && addr_i == ADDR_MASK) ? wdata_i[NUM_CH-1:0] : mask_q;

      rdata_d = rdata_q;
      if (rd_en_i) begin
         unique case (addr_i)
            ADDR_STATUS:  rdata_d = W'(live_q);
            ADDR_EVENT:   rdata_d = W'(event_q);
            ADDR_MASK:    rdata_d = W'(mask_q);
            ADDR_OVERRUN: rdata_d = W'(overrun_q);
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         live_q    <= '0;
         event_q   <= '0;
         overrun_q <= '0;
         mask_q    <= '1;
         rdata_q   <= '0;
      end else begin
         live_q    <= live_d;
         event_q   <= event_d;
         overrun_q <= overrun_d;
         mask_q    <= mask_d;
         rdata_q   <= rdata_d;
      end
   end

`ifdef UART_STATUS_IRQ_HOLDOFF_EN
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2
   } irq_state_e;

   irq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // irq register follows the next state so assertion latency matches the plain path.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear_flags_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (pending) state_d = ST_ASSERT;
            ST_ASSERT: begin
               if (!pending) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LOAD;
               end
            end
            ST_HOLD: begin
               if (cnt_q == '0) state_d = pending ? ST_ASSERT : ST_IDLE;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      irq_d = (state_d == ST_ASSERT);
   end
`else
   always_comb begin
      irq_d = pending;
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end

   assign rdata_o = rdata_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_uart_status_irq_ctrl.sv
// Directed self-checking bench for uart_status_irq_ctrl (NUM_CH=2, HOLDOFF_CYCLES=16).
module tb_uart_status_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] active, done;
   logic       clear_flags;
   logic [1:0] addr;
   logic       wr_en, rd_en;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       irq;

   int checks   = 0;
   int failures = 0;

   uart_status_irq_ctrl #(.NUM_CH(2), .HOLDOFF_CYCLES(16)) dut (
      .clk_i(clk), .rst_i(rst), .active_i(active), .done_i(done),
      .clear_flags_i(clear_flags), .addr_i(addr), .wr_en_i(wr_en),
      .wdata_i(wdata), .rd_en_i(rd_en), .rdata_o(rdata), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
      wr_en = w; rd_en = r; addr = a; wdata = d;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
      bus(1'b0, 1'b1, a, 8'h00);
      check(tag, rdata, exp);
   endtask

   task automatic pulse(input logic [1:0] d, input logic clr);
      done = d; clear_flags = clr;
      tick();
      done = '0; clear_flags = 1'b0;
   endtask

   initial begin
      logic [7:0] exp;
      rst = 1'b1; active = '0; done = '0; clear_flags = 1'b0;
      addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
      tick(); tick();
      check("reset_irq", 8'(irq), 8'h00);
      check("reset_rdata", rdata, 8'h00);
      rst = 1'b0;
      tick();
      rd_check("reset_mask", 2'd2, 8'h03);
      rd_check("reset_event", 2'd1, 8'h00);

      // Live mirror; STATUS writes ignored
      active = 2'b01;
      bus(1'b1, 1'b0, 2'd0, 8'hFF);
      rd_check("status_live", 2'd0, 8'h01);

      // done[1] pulse -> event next cycle, irq the cycle after
      pulse(2'b10, 1'b0);
      check("irq_lat1", 8'(irq), 8'h00);
      tick();
      check("irq_lat2", 8'(irq), 8'h01);
      rd_check("event_d1", 2'd1, 8'h02);
      bus(1'b1, 1'b0, 2'd1, 8'h02);
      check("irq_after_w1c0", 8'(irq), 8'h01);
      tick();
      check("irq_after_w1c1", 8'(irq), 8'h00);

      // Overrun and done-vs-W1C simultaneity
      pulse(2'b01, 1'b0);
      pulse(2'b01, 1'b0);
      rd_check("overrun_set", 2'd3, 8'h01);
      done = 2'b01;
      bus(1'b1, 1'b0, 2'd1, 8'h01);
      done = '0;
      rd_check("event_kept", 2'd1, 8'h01);
      rd_check("overrun_same", 2'd3, 8'h01);
      bus(1'b1, 1'b1, 2'd1, 8'h01);
      check("rd_pre_write", rdata, 8'h01);
      rd_check("event_w1c", 2'd1, 8'h00);
      bus(1'b1, 1'b0, 2'd3, 8'h01);
      rd_check("overrun_w1c", 2'd3, 8'h00);
      tick();
      check("irq_idle", 8'(irq), 8'h00);

      // Mask gating; upper wdata bits dropped
      bus(1'b1, 1'b0, 2'd2, 8'hFC);
      rd_check("mask_upper", 2'd2, 8'h00);
      pulse(2'b01, 1'b0);
      tick();
      rd_check("masked_event", 2'd1, 8'h01);
      check("masked_irq", 8'(irq), 8'h00);
      bus(1'b1, 1'b0, 2'd2, 8'h01);
      check("unmask_irq0", 8'(irq), 8'h00);
      tick();
      check("unmask_irq1", 8'(irq), 8'h01);

      // clear_flags beats same-cycle done[1]
      pulse(2'b01, 1'b0);
      rd_check("overrun_pre_clr", 2'd3, 8'h01);
      pulse(2'b10, 1'b1);
      check("clr_irq0", 8'(irq), 8'h01);
      tick();
      check("clr_irq1", 8'(irq), 8'h00);
      rd_check("clr_event", 2'd1, 8'h00);
      rd_check("clr_overrun", 2'd3, 8'h00);
      rd_check("clr_mask", 2'd2, 8'h01);
      tick(); tick();
      check("rdata_hold", rdata, 8'h01);

      // Asynchronous reset mid-run with events pending
      pulse(2'b11, 1'b0);
      tick();
      #3 rst = 1'b1;
      #1;
      check("async_irq", 8'(irq), 8'h00);
      check("async_rdata", rdata, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      rd_check("async_mask", 2'd2, 8'h03);
      rd_check("async_event", 2'd1, 8'h00);
      rd_check("async_overrun", 2'd3, 8'h00);

      // Re-raise shortly after a fall: holdoff delays it, plain path does not
      pulse(2'b01, 1'b0);
      tick();
      check("ho_irq_up", 8'(irq), 8'h01);
      bus(1'b1, 1'b0, 2'd1, 8'h01);
      for (int k = 1; k <= 17; k++) begin
         if (k == 3) done = 2'b01;
         tick();
         done = '0;
`ifdef UART_STATUS_IRQ_HOLDOFF_EN
         exp = (k == 17) ? 8'h01 : 8'h00;
`else
         exp = (k >= 4) ? 8'h01 : 8'h00;
`endif
         check($sformatf("reraise_k%0d", k), 8'(irq), exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
